afifo_read_sched: RTL and testbench
===================================

Name: afifo_read_sched

Overview:
Read-side scheduler that shares one async FIFO read port among NReq consumers in the rclk domain. Grants the port in round-robin bursts, issues pops, and returns popped data tagged with the owning requester. Sits directly between the FIFO read interface (r/rd/rempty) and the consumers.

Parameters:
Width, 12, FIFO data width
NReq, 4, number of requesters (>=2)
BurstLen, 8, max pops per grant (>=1, any integer)
StallMax, 16, consecutive non-pop BURST cycles before forced release (>=1)

Ports:
rclk  in  1  read-domain clock
dirclr  in  1  reset, asynchronous, active-high
fifo_rd  in  Width  FIFO head data (show-ahead, valid when !fifo_rempty)
fifo_rempty  in  1  FIFO empty flag (already rclk-synchronous)
fifo_r  out  1  FIFO pop strobe
req  in  NReq  per-requester request, level
ready  in  NReq  per-requester accept-data
grant  out  NReq  one-hot current owner, 0 when none
dout  out  Width  popped data, registered
dout_valid  out  1  one-cycle pulse, dout valid
dout_owner  out  $clog2(NReq)  binary index of requester owning dout
burst_done  out  1  one-cycle pulse on grant release

Behaviour:
- Reset value of all outputs is 0 (grant=0, dout=0, dout_valid=0, dout_owner=0, burst_done=0, fifo_r=0); state=IDLE, rr pointer=NReq-1 (requester 0 wins first), pop/stall counters=0.
- dirclr is async: fifo_r and grant drop immediately with dirclr, not at the next edge; an in-flight burst is abandoned, no burst_done.
- States: IDLE, BURST, RELEASE.
- IDLE: if any req bit set, pick first set bit scanning from rr+1 upward with wrap; register grant=onehot(winner), owner=winner, counters=0 -> BURST. No req: stay IDLE.
- BURST:
  - pop = req[owner] & ready[owner] & !fifo_rempty; fifo_r = pop (combinational from registered state and inputs, only in BURST).
  - On pop: dout<=fifo_rd, dout_owner<=owner, dout_valid<=1 next cycle (latency 1 edge); popcnt++, stallcnt<=0.
  - No pop: stallcnt++.
  - Exit to RELEASE when: req[owner]==0 (takes priority, no pop that cycle); or pop with popcnt==BurstLen-1; or no-pop with stallcnt==StallMax-1.
- RELEASE: grant=0, fifo_r=0, burst_done=1 for this one cycle, rr<=owner -> IDLE. Minimum gap between grants: 2 cycles (RELEASE, IDLE).
- Counter widths: popcnt $clog2(BurstLen+1), stallcnt $clog2(StallMax+1); neither wraps (exit precedes overflow).
- fifo_r never asserted while fifo_rempty=1; at most BurstLen pops per grant.
- grant always one-hot or zero; grant changes only on rclk edges (or dirclr).
- Requester raising req during another's burst waits; starvation bound: NReq-1 bursts.
- dout holds last value when dout_valid=0.

Test Plan:
- Reset: dirclr=1 mid-BURST with fifo_r=1 -> fifo_r, grant go 0 without clock edge; after release, req=0001 -> grant=0001 two edges later.
- Single requester, FIFO holds 10 words 0x000..0x009, BurstLen=8, ready=1 -> 8 pops, dout 0x000..0x007 with dout_owner=0, burst_done, 2-cycle gap, next grant pops 0x008,0x009.
- Round-robin: req=1111 held, FIFO always non-empty -> grant sequence 0001,0010,0100,1000,0001, each exactly 8 dout_valid pulses.
- Back-pressure: ready[owner] toggles 1/0 every cycle -> pops only on ready=1 cycles, data order preserved, no words lost or duplicated.
- Empty stall: grant to req 2, FIFO empty 16 cycles -> release on 16th cycle, burst_done=1, no fifo_r; req 3 granted next.
- Req drop: owner drops req in same cycle FIFO non-empty & ready=1 -> no pop that cycle, RELEASE next, popcnt discarded.

Source files
------------

// File: rtl/afifo_read_sched.sv
// Read-side scheduler: shares one async-FIFO read port among NReq consumers.
// The port is granted round-robin in bursts of at most BurstLen pops. A burst
// ends early when the owner drops its request or the FIFO stays unpoppable
// for StallMax consecutive cycles. Popped words come out one cycle later,
// tagged with the index of the requester that owned the pop.
module afifo_read_sched #(
   parameter  int Width    = 12,
   parameter  int NReq     = 4,
   parameter  int BurstLen = 8,
   parameter  int StallMax = 16,
   localparam int OwnerW   = $clog2(NReq)
) (
   input  logic              rclk,
   input  logic              dirclr,
   input  logic [Width-1:0]  fifo_rd,
   input  logic              fifo_rempty,
   output logic              fifo_r,
   input  logic [NReq-1:0]   req,
   input  logic [NReq-1:0]   ready,
   output logic [NReq-1:0]   grant,
   output logic [Width-1:0]  dout,
   output logic              dout_valid,
   output logic [OwnerW-1:0] dout_owner,
   output logic              burst_done
);

   localparam int PopW   = $clog2(BurstLen + 1);
   localparam int StallW = $clog2(StallMax + 1);

   // Terminal counts: the exit decision is taken on the cycle that would
   // reach the limit, so neither counter ever wraps.
   localparam logic [PopW-1:0]   POP_LAST   = PopW'(BurstLen - 1);
   localparam logic [StallW-1:0] STALL_LAST = StallW'(StallMax - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BURST   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [OwnerW-1:0]   owner;
   logic [OwnerW-1:0]   rr;
   logic [PopW-1:0]     popcnt;
   logic [StallW-1:0]   stallcnt;
   logic [OwnerW-1:0]   winner;
   logic                win_found;
   logic                own_req;
   logic                own_rdy;
   logic                pop;

   assign own_req = req[owner];
   assign own_rdy = ready[owner];

   // A pop needs an active burst, a requesting and ready owner, and data at the head.
   assign pop = (state == BURST) && own_req && own_rdy && !fifo_rempty;

   // Round-robin arbiter: first set request scanning upward from rr+1 with wrap.
   always_comb begin
      // NOTE: every variable written in a combinational block gets a default
      // first, so no path through the block can leave it holding (a latch).
      winner    = '0;
      win_found = 1'b0;
      for (int i = 1; i <= NReq; i++) begin
         if (!win_found && req[(int'(rr) + i) % NReq]) begin
            winner    = OwnerW'((int'(rr) + i) % NReq);
            win_found = 1'b1;
         end
      end
   end

   // State register; dirclr abandons any burst immediately.
   always_ff @(posedge rclk or posedge dirclr) begin
      if (dirclr) begin
         // NOTE: clocked state uses non-blocking assignments so every register
         // samples the pre-edge values, independent of block evaluation order.
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a dropped owner request outranks both burst limits.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (win_found) state_nxt = BURST;
         end
         BURST: begin
            if (!own_req)                    state_nxt = RELEASE;
            else if (pop && popcnt == POP_LAST) state_nxt = RELEASE;
            else if (!pop && stallcnt == STALL_LAST) state_nxt = RELEASE;
         end
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from registered state so grant only moves on edges or dirclr.
   always_comb begin
      fifo_r     = pop;
      grant      = '0;
      burst_done = 1'b0;
      if (state == BURST)   grant      = NReq'(1) << owner;
      if (state == RELEASE) burst_done = 1'b1;
   end

   // Burst bookkeeping: owner capture, pop/stall counting, round-robin pointer.
   always_ff @(posedge rclk or posedge dirclr) begin
      if (dirclr) begin
         owner    <= '0;
         rr       <= OwnerW'(NReq - 1);
         popcnt   <= '0;
         stallcnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (win_found) owner <= winner;
               popcnt   <= '0;
               stallcnt <= '0;
            end
            BURST: begin
               if (pop) begin
                  popcnt   <= popcnt + PopW'(1);
                  stallcnt <= '0;
               end else begin
                  stallcnt <= stallcnt + StallW'(1);
               end
            end
            RELEASE: rr <= owner;
            default: ;
         endcase
      end
   end

   // Return path: popped word and its owner, valid for exactly one cycle.
   always_ff @(posedge rclk or posedge dirclr) begin
      if (dirclr) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_owner <= '0;
      end else begin
         dout_valid <= pop;
         if (pop) begin
            dout       <= fifo_rd;
            dout_owner <= owner;
         end
      end
   end

endmodule

// File: tb/tb_afifo_read_sched.sv
// Directed bench for afifo_read_sched with a show-ahead FIFO model on the read side.
module tb_afifo_read_sched;

   localparam int W  = 12;
   localparam int N  = 4;
   localparam int OW = $clog2(N);

   logic          rclk = 1'b0;
   logic          dirclr;
   logic [W-1:0]  fifo_rd;
   logic          fifo_rempty;
   logic          fifo_r;
   logic [N-1:0]  req;
   logic [N-1:0]  ready;
   logic [N-1:0]  grant;
   logic [W-1:0]  dout;
   logic          dout_valid;
   logic [OW-1:0] dout_owner;
   logic          burst_done;

   int checks = 0;
   int errors = 0;

   // FIFO model: head advances on pops, tail is written by the stimulus tasks.
   logic [W-1:0] mem [0:1023];
   int head;
   int tail;

   // Output monitor state.
   logic [W-1:0]  log_data  [$];
   logic [OW-1:0] log_owner [$];
   int bd_cnt    = 0;
   int bad_pop   = 0;
   int bad_grant = 0;

   afifo_read_sched #(.Width(W), .NReq(N), .BurstLen(8), .StallMax(16)) dut (
      .rclk        (rclk),
      .dirclr      (dirclr),
      .fifo_rd     (fifo_rd),
      .fifo_rempty (fifo_rempty),
      .fifo_r      (fifo_r),
      .req         (req),
      .ready       (ready),
      .grant       (grant),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_owner  (dout_owner),
      .burst_done  (burst_done)
   );

   always #5 rclk = ~rclk;

   always @(posedge rclk or posedge dirclr) begin
      if (dirclr) head <= 0;
      else if (fifo_r) head <= head + 1;
   end

   assign fifo_rempty = (head == tail);
   assign fifo_rd     = mem[head % 1024];

   always @(negedge rclk) begin
      if (dout_valid) begin
         log_data.push_back(dout);
         log_owner.push_back(dout_owner);
      end
      if (burst_done) bd_cnt++;
      if (fifo_r && fifo_rempty) bad_pop++;
      if (!$onehot0(grant)) bad_grant++;
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic push_word(input logic [W-1:0] w);
      mem[tail % 1024] = w;
      tail = tail + 1;
   endtask

   task automatic reset_all();
      dirclr = 1'b1;
      req    = '0;
      ready  = '0;
      tail   = 0;
      @(posedge rclk);
      #1;
      dirclr = 1'b0;
   endtask

   task automatic test_reset();
      int bd0;
      dirclr = 1'b1;
      req    = '0;
      ready  = '0;
      tail   = 0;
      #3;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
      checks++; if (fifo_r !== 1'b0) begin errors++; $display("FAIL reset_fifo_r: got %b want 0", fifo_r); end
      checks++; if (dout !== 12'h000) begin errors++; $display("FAIL reset_dout: got %h want 000", dout); end
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
      checks++; if (dout_owner !== 2'd0) begin errors++; $display("FAIL reset_dout_owner: got %0d want 0", dout_owner); end
      checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_burst_done: got %b want 0", burst_done); end
      @(posedge rclk);
      #1;
      dirclr = 1'b0;
      push_word(12'hA00);
      push_word(12'hA01);
      push_word(12'hA02);
      req   = 4'b0001;
      ready = 4'b0001;
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_pre_grant: got %b want 0001", grant); end
      checks++; if (fifo_r !== 1'b1) begin errors++; $display("FAIL reset_pre_fifo_r: got %b want 1", fifo_r); end
      // Assert dirclr between edges: outputs must drop without a clock.
      bd0 = bd_cnt;
      #1 dirclr = 1'b1;
      #1;
      checks++; if (fifo_r !== 1'b0) begin errors++; $display("FAIL reset_async_fifo_r: got %b want 0", fifo_r); end
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_async_grant: got %b want 0000", grant); end
      @(posedge rclk);
      #1;
      dirclr = 1'b0;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_release_grant: got %b want 0000", grant); end
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_regrant1: got %b want 0001", grant); end
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_regrant2: got %b want 0001", grant); end
      checks++; if (bd_cnt != bd0) begin errors++; $display("FAIL reset_no_burst_done: got %0d pulses want 0", bd_cnt - bd0); end
   endtask

   task automatic test_single_burst();
      int base;
      int bd0;
      logic [N-1:0] eg;
      reset_all();
      base = log_data.size();
      bd0  = bd_cnt;
      for (int i = 0; i < 10; i++) push_word(W'(i));
      req   = 4'b0001;
      ready = 4'b1111;
      for (int c = 1; c <= 13; c++) begin
         tick();
         eg = (c == 9 || c == 10) ? 4'b0000 : 4'b0001;
         checks++; if (grant !== eg) begin errors++; $display("FAIL single_grant c=%0d: got %b want %b", c, grant, eg); end
         checks++; if (burst_done !== (c == 9)) begin errors++; $display("FAIL single_burst_done c=%0d: got %b want %b", c, burst_done, (c == 9)); end
      end
      req = '0;
      repeat (3) tick();
      checks++; if (log_data.size() - base != 10) begin errors++; $display("FAIL single_count: got %0d want 10", log_data.size() - base); end
      else begin
         for (int i = 0; i < 10; i++) begin
            checks++; if (log_data[base + i] !== W'(i) || log_owner[base + i] !== 2'd0) begin
               errors++; $display("FAIL single_data[%0d]: got %h/%0d want %h/0", i, log_data[base + i], log_owner[base + i], W'(i));
            end
         end
      end
      checks++; if (bd_cnt - bd0 != 2) begin errors++; $display("FAIL single_bd_count: got %0d want 2", bd_cnt - bd0); end
   endtask

   task automatic test_round_robin();
      int base;
      int bd0;
      logic [N-1:0] last;
      logic [N-1:0] seq [$];
      logic [N-1:0] exp_seq [5];
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      reset_all();
      base = log_data.size();
      bd0  = bd_cnt;
      last = '0;
      for (int i = 0; i < 48; i++) push_word(W'(12'h300 + i));
      req   = 4'b1111;
      ready = 4'b1111;
      for (int c = 1; c <= 50; c++) begin
         tick();
         if (grant == '0) last = '0;
         else if (grant !== last) begin
            seq.push_back(grant);
            last = grant;
         end
      end
      req = '0;
      repeat (3) tick();
      checks++; if (seq.size() != 5) begin errors++; $display("FAIL rr_grant_count: got %0d want 5", seq.size()); end
      else begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, seq[i], exp_seq[i]); end
         end
      end
      checks++; if (log_data.size() - base != 40) begin errors++; $display("FAIL rr_pop_count: got %0d want 40", log_data.size() - base); end
      else begin
         for (int i = 0; i < 40; i++) begin
            checks++; if (log_data[base + i] !== W'(12'h300 + i) || log_owner[base + i] !== OW'((i / 8) % 4)) begin
               errors++; $display("FAIL rr_data[%0d]: got %h/%0d want %h/%0d", i, log_data[base + i], log_owner[base + i], W'(12'h300 + i), (i / 8) % 4);
            end
         end
      end
      checks++; if (bd_cnt - bd0 != 5) begin errors++; $display("FAIL rr_bd_count: got %0d want 5", bd_cnt - bd0); end
   endtask

   task automatic test_back_pressure();
      int base;
      reset_all();
      base = log_data.size();
      for (int i = 0; i < 12; i++) push_word(W'(12'h100 + i));
      req   = 4'b0001;
      ready = 4'b0001;
      tick();
      for (int c = 0; c < 16; c++) begin
         ready = (c % 2 == 0) ? 4'b0001 : 4'b0000;
         #1;
         checks++; if (fifo_r !== ready[0]) begin errors++; $display("FAIL bp_fifo_r c=%0d: got %b want %b", c, fifo_r, ready[0]); end
         tick();
      end
      req = '0;
      repeat (3) tick();
      checks++; if (log_data.size() - base != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", log_data.size() - base); end
      else begin
         for (int i = 0; i < 8; i++) begin
            checks++; if (log_data[base + i] !== W'(12'h100 + i) || log_owner[base + i] !== 2'd0) begin
               errors++; $display("FAIL bp_data[%0d]: got %h/%0d want %h/0", i, log_data[base + i], log_owner[base + i], W'(12'h100 + i));
            end
         end
      end
      checks++; if (head != 8) begin errors++; $display("FAIL bp_fifo_head: got %0d want 8", head); end
      checks++; if (dout !== 12'h107 || dout_valid !== 1'b0) begin errors++; $display("FAIL bp_dout_hold: got %h/%b want 107/0", dout, dout_valid); end
   endtask

   task automatic test_empty_stall();
      logic [N-1:0] eg;
      reset_all();
      req   = 4'b1100;
      ready = 4'b1111;
      for (int c = 1; c <= 19; c++) begin
         tick();
         eg = (c <= 16) ? 4'b0100 : (c <= 18) ? 4'b0000 : 4'b1000;
         checks++; if (grant !== eg) begin errors++; $display("FAIL stall_grant c=%0d: got %b want %b", c, grant, eg); end
         checks++; if (burst_done !== (c == 17)) begin errors++; $display("FAIL stall_burst_done c=%0d: got %b want %b", c, burst_done, (c == 17)); end
         checks++; if (fifo_r !== 1'b0) begin errors++; $display("FAIL stall_fifo_r c=%0d: got %b want 0", c, fifo_r); end
      end
      req = '0;
      repeat (3) tick();
   endtask

   task automatic test_req_drop();
      int base;
      reset_all();
      base = log_data.size();
      for (int i = 0; i < 5; i++) push_word(W'(12'h200 + i));
      req   = 4'b0011;
      ready = 4'b1111;
      repeat (3) tick();
      req = 4'b0010;
      #1;
      checks++; if (fifo_r !== 1'b0) begin errors++; $display("FAIL drop_fifo_r: got %b want 0", fifo_r); end
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL drop_grant_hold: got %b want 0001", grant); end
      tick();
      checks++; if (grant !== 4'b0000 || burst_done !== 1'b1) begin errors++; $display("FAIL drop_release: got %b/%b want 0000/1", grant, burst_done); end
      checks++; if (head != 2) begin errors++; $display("FAIL drop_head: got %0d want 2", head); end
      tick();
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drop_idle_grant: got %b want 0000", grant); end
      tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL drop_next_grant: got %b want 0010", grant); end
      repeat (4) tick();
      req = '0;
      repeat (3) tick();
      checks++; if (log_data.size() - base != 5) begin errors++; $display("FAIL drop_count: got %0d want 5", log_data.size() - base); end
      else begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (log_data[base + i] !== W'(12'h200 + i) || log_owner[base + i] !== ((i < 2) ? 2'd0 : 2'd1)) begin
               errors++; $display("FAIL drop_data[%0d]: got %h/%0d want %h/%0d", i, log_data[base + i], log_owner[base + i], W'(12'h200 + i), (i < 2) ? 0 : 1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_back_pressure();
      test_empty_stall();
      test_req_drop();
      checks++; if (bad_pop != 0) begin errors++; $display("FAIL pop_while_empty: got %0d want 0", bad_pop); end
      checks++; if (bad_grant != 0) begin errors++; $display("FAIL grant_onehot: got %0d bad cycles want 0", bad_grant); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
